// File: rtl/dev_bridge.sv
// CPU-to-device register bridge: decodes the device window and runs one
// register access at a time over the shared device register bus.
module dev_bridge #(
  parameter int          N_DEV       = 3,
  parameter logic [31:0] BASE        = 32'h0000_7F00,
  parameter int          DEV_ADDR_WD = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cpu_req_i,
  input  logic                   cpu_we_i,
  input  logic [31:0]            cpu_addr_i,
  input  logic [31:0]            cpu_wdata_i,
  output logic                   cpu_ack_o,
  output logic                   cpu_err_o,
  output logic [31:0]            cpu_rdata_o,
  output logic [5:0]             hwint_o,
  output logic [DEV_ADDR_WD-1:0] dev_add_o,
  output logic [N_DEV-1:0]       dev_we_o,
  output logic [31:0]            dev_dat_o,
  input  logic [32*N_DEV-1:0]    dev_dat_i,
  input  logic [N_DEV-1:0]       dev_irq_i
);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP,
    ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        we_q;
  logic [2:0]  sel_q;
  logic [31:0] rdata_q;
  logic [31:0] dev_idx;
  logic        decode_ok;
  logic [31:0] rd_slice;

  // The subtraction wraps below BASE; the explicit >= test rejects those.
  assign dev_idx   = (cpu_addr_i - BASE) >> 4;
  assign decode_ok = (cpu_addr_i >= BASE) &&
                     (dev_idx < 32'(N_DEV)) &&
                     (cpu_addr_i[1:0] == 2'b00) &&
                     (cpu_addr_i[3:2] != 2'b11);

  assign cpu_rdata_o = rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_ack_o = 1'b0;
    cpu_err_o = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req_i) begin
          state_nxt = decode_ok ? ACCESS : ERR;
        end
      end
      ACCESS: begin
        state_nxt = we_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        state_nxt = RESP;
      end
      RESP: begin
        cpu_ack_o = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        cpu_ack_o = 1'b1;
        cpu_err_o = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    dev_we_o = '0;
    rd_slice = '0;
    for (int k = 0; k < N_DEV; k++) begin
      if (sel_q == 3'(k)) begin
        dev_we_o[k] = (state == ACCESS) && we_q;
        rd_slice    = dev_dat_i[32*k +: 32];
      end
    end
  end

  // Device-side fields only move on a valid decode so the bus stays quiet on errors.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q      <= 1'b0;
      sel_q     <= '0;
      dev_add_o <= '0;
      dev_dat_o <= '0;
      rdata_q   <= '0;
      hwint_o   <= '0;
    end else begin
      hwint_o <= 6'(dev_irq_i);
      if (state == IDLE && cpu_req_i) begin
        we_q <= cpu_we_i;
        if (decode_ok) begin
          sel_q     <= dev_idx[2:0];
          dev_add_o <= DEV_ADDR_WD'(cpu_addr_i[3:2]);
          if (cpu_we_i) begin
            dev_dat_o <= cpu_wdata_i;
          end
        end else begin
          rdata_q <= '0;
        end
      end
      if (state == CAPTURE) begin
        rdata_q <= rd_slice;
      end
    end
  end

endmodule

// File: tb/tb_dev_bridge.sv
// Testbench for dev_bridge: timer-like device stubs on the register bus and
// an address-rule reference model of what the CPU should observe.
module tb_dev_bridge;

  localparam int          N_DEV = 3;
  localparam logic [31:0] BASE  = 32'h0000_7F00;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [31:0]       cpu_addr_i;
  logic [31:0]       cpu_wdata_i;
  logic              cpu_ack_o;
  logic              cpu_err_o;
  logic [31:0]       cpu_rdata_o;
  logic [5:0]        hwint_o;
  logic [1:0]        dev_add_o;
  logic [N_DEV-1:0]  dev_we_o;
  logic [31:0]       dev_dat_o;
  logic [32*N_DEV-1:0] dev_dat_i;
  logic [N_DEV-1:0]  dev_irq_i;

  int n_checks = 0;
  int n_pass   = 0;

  dev_bridge #(.N_DEV(N_DEV), .BASE(BASE), .DEV_ADDR_WD(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o), .cpu_rdata_o(cpu_rdata_o),
    .hwint_o(hwint_o), .dev_add_o(dev_add_o), .dev_we_o(dev_we_o),
    .dev_dat_o(dev_dat_o), .dev_dat_i(dev_dat_i), .dev_irq_i(dev_irq_i)
  );

  always #5 clk_i = ~clk_i;

  // Device stubs: CTRL/PRESET writable, COUNT read-only, read data registered from the index.
  logic [31:0] dev_regs [N_DEV][4];
  logic [31:0] dev_rd   [N_DEV];

  always @(posedge clk_i) begin
    for (int k = 0; k < N_DEV; k++) begin
      if (rst_i) begin
        dev_regs[k][0] <= 32'h0;
        dev_regs[k][1] <= 32'h0;
        dev_regs[k][2] <= 32'hC0DE_0000 + 32'(k);
        dev_regs[k][3] <= 32'h0;
        dev_rd[k]      <= 32'h0;
      end else begin
        if (dev_we_o[k] && dev_add_o < 2'd2) dev_regs[k][dev_add_o] <= dev_dat_o;
        dev_rd[k] <= dev_regs[k][dev_add_o];
      end
    end
  end

  assign dev_dat_i = {dev_rd[2], dev_rd[1], dev_rd[0]};

  // Reference model: register contents as seen by the CPU.
  logic [31:0] ref_regs [N_DEV][3];

  int          obs_ack_cyc;
  int          obs_we_cyc;
  int          obs_we_count;
  logic        obs_err;
  logic [31:0] obs_rdata;
  logic [31:0] obs_dat;
  logic [2:0]  obs_we_val;
  logic [1:0]  obs_add;
  logic [1:0]  obs_add1;
  logic [1:0]  obs_add2;

  // Issues one request from an IDLE cycle and returns in the next IDLE cycle.
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req_i    = 1'b1;
    cpu_we_i     = we;
    cpu_addr_i   = addr;
    cpu_wdata_i  = wdata;
    obs_ack_cyc  = 0;
    obs_we_cyc   = 0;
    obs_we_count = 0;
    obs_err      = 1'bx;
    obs_rdata    = 'x;
    obs_dat      = 'x;
    obs_we_val   = 'x;
    obs_add      = 'x;
    obs_add1     = 'x;
    obs_add2     = 'x;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk_i);
      #1;
      if (n == 1) cpu_req_i = 1'b0;
      if (n == 1) obs_add1 = dev_add_o;
      if (n == 2) obs_add2 = dev_add_o;
      if (dev_we_o !== '0) begin
        obs_we_count++;
        if (obs_we_cyc == 0) begin
          obs_we_cyc = n;
          obs_we_val = dev_we_o;
          obs_add    = dev_add_o;
          obs_dat    = dev_dat_o;
        end
      end
      if (cpu_ack_o === 1'b1) begin
        obs_ack_cyc = n;
        obs_err     = cpu_err_o;
        obs_rdata   = cpu_rdata_o;
        break;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++; if (cpu_ack_o !== 1'b0) $display("[TB] FAIL reset_ack: got %b expected 0", cpu_ack_o); else n_pass++;
    n_checks++; if (cpu_err_o !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", cpu_err_o); else n_pass++;
    n_checks++; if (cpu_rdata_o !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected 0", cpu_rdata_o); else n_pass++;
    n_checks++; if (hwint_o !== 6'h0) $display("[TB] FAIL reset_hwint: got %b expected 0", hwint_o); else n_pass++;
    n_checks++; if (dev_we_o !== 3'b000) $display("[TB] FAIL reset_dev_we: got %b expected 000", dev_we_o); else n_pass++;
    n_checks++; if (dev_add_o !== 2'd0) $display("[TB] FAIL reset_dev_add: got %0d expected 0", dev_add_o); else n_pass++;
    n_checks++; if (dev_dat_o !== 32'h0) $display("[TB] FAIL reset_dev_dat: got %h expected 0", dev_dat_o); else n_pass++;
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      n_checks++;
      if (dev_we_o !== 3'b000 || cpu_ack_o !== 1'b0)
        $display("[TB] FAIL idle_quiet: got we=%b ack=%b expected we=000 ack=0", dev_we_o, cpu_ack_o);
      else n_pass++;
    end
  endtask

  task automatic test_preset_write();
    cpu_access(1'b1, 32'h7F04, 32'd5);
    n_checks++; if (obs_ack_cyc !== 2) $display("[TB] FAIL wr_ack_cycle: got %0d expected 2", obs_ack_cyc); else n_pass++;
    n_checks++; if (obs_err !== 1'b0) $display("[TB] FAIL wr_err: got %b expected 0", obs_err); else n_pass++;
    n_checks++; if (obs_we_cyc !== 1) $display("[TB] FAIL wr_we_cycle: got %0d expected 1", obs_we_cyc); else n_pass++;
    n_checks++; if (obs_we_count !== 1) $display("[TB] FAIL wr_we_len: got %0d expected 1", obs_we_count); else n_pass++;
    n_checks++; if (obs_we_val !== 3'b001) $display("[TB] FAIL wr_we_val: got %b expected 001", obs_we_val); else n_pass++;
    n_checks++; if (obs_add !== 2'd1) $display("[TB] FAIL wr_add: got %0d expected 1", obs_add); else n_pass++;
    n_checks++; if (obs_dat !== 32'd5) $display("[TB] FAIL wr_dat: got %h expected 5", obs_dat); else n_pass++;
    ref_regs[0][1] = 32'd5;
  endtask

  task automatic test_read_after_write();
    cpu_access(1'b1, 32'h7F10, 32'h9);
    ref_regs[1][0] = 32'h9;
    n_checks++; if (obs_we_val !== 3'b010) $display("[TB] FAIL raw_wr_we: got %b expected 010", obs_we_val); else n_pass++;
    cpu_access(1'b0, 32'h7F10, 32'h0);
    n_checks++; if (obs_ack_cyc !== 3) $display("[TB] FAIL rd_ack_cycle: got %0d expected 3", obs_ack_cyc); else n_pass++;
    n_checks++; if (obs_err !== 1'b0) $display("[TB] FAIL rd_err: got %b expected 0", obs_err); else n_pass++;
    n_checks++; if (obs_rdata !== ref_regs[1][0]) $display("[TB] FAIL rd_data: got %h expected %h", obs_rdata, ref_regs[1][0]); else n_pass++;
    n_checks++; if (obs_we_count !== 0) $display("[TB] FAIL rd_no_we: got %0d pulses expected 0", obs_we_count); else n_pass++;
    n_checks++; if (obs_add1 !== 2'd0 || obs_add2 !== 2'd0) $display("[TB] FAIL rd_add_hold: got %0d,%0d expected 0,0", obs_add1, obs_add2); else n_pass++;
  endtask

  task automatic test_decode_errors();
    logic [31:0] bad_addr [4];
    bad_addr[0] = 32'h7F0C;
    bad_addr[1] = 32'h7F02;
    bad_addr[2] = 32'h7F30;
    bad_addr[3] = 32'h7EFC;
    for (int i = 0; i < 4; i++) begin
      cpu_access(1'b0, 32'h7F10, 32'h0);
      cpu_access(1'b1, bad_addr[i], $urandom);
      n_checks++; if (obs_ack_cyc !== 1) $display("[TB] FAIL err_ack_cycle @%h: got %0d expected 1", bad_addr[i], obs_ack_cyc); else n_pass++;
      n_checks++; if (obs_err !== 1'b1) $display("[TB] FAIL err_flag @%h: got %b expected 1", bad_addr[i], obs_err); else n_pass++;
      n_checks++; if (obs_rdata !== 32'h0) $display("[TB] FAIL err_rdata @%h: got %h expected 0", bad_addr[i], obs_rdata); else n_pass++;
      n_checks++; if (obs_we_count !== 0) $display("[TB] FAIL err_no_we @%h: got %0d pulses expected 0", bad_addr[i], obs_we_count); else n_pass++;
    end
  endtask

  task automatic test_irq();
    logic [2:0] prev;
    dev_irq_i = 3'b010;
    #1;
    n_checks++; if (hwint_o !== 6'b000000) $display("[TB] FAIL irq_rise_early: got %b expected 000000", hwint_o); else n_pass++;
    @(posedge clk_i);
    #1;
    n_checks++; if (hwint_o !== 6'b000010) $display("[TB] FAIL irq_rise: got %b expected 000010", hwint_o); else n_pass++;
    dev_irq_i = 3'b000;
    #1;
    n_checks++; if (hwint_o !== 6'b000010) $display("[TB] FAIL irq_fall_early: got %b expected 000010", hwint_o); else n_pass++;
    @(posedge clk_i);
    #1;
    n_checks++; if (hwint_o !== 6'b000000) $display("[TB] FAIL irq_fall: got %b expected 000000", hwint_o); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      prev      = 3'($urandom);
      dev_irq_i = prev;
      @(posedge clk_i);
      #1;
      n_checks++; if (hwint_o !== {3'b000, prev}) $display("[TB] FAIL irq_follow: got %b expected %b", hwint_o, {3'b000, prev}); else n_pass++;
    end
    dev_irq_i = 3'b000;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] off;
    logic        we;
    logic        valid;
    int          dev;
    int          rsel;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: addr = BASE - 32'(4 * $urandom_range(1, 64));
        1: addr = $urandom;
        default: addr = BASE + 32'(16 * $urandom_range(0, 4)) + 32'(4 * $urandom_range(0, 3)) +
                        (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      endcase
      we    = 1'($urandom);
      wdata = $urandom;
      off   = addr - BASE;
      dev   = int'(off / 16);
      rsel  = int'((addr / 4) % 4);
      valid = (addr >= BASE) && (off / 16 < N_DEV) && (addr % 4 == 0) && (rsel != 3);
      cpu_access(we, addr, wdata);
      if (!valid) begin
        n_checks++;
        if (obs_ack_cyc !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_we_count !== 0)
          $display("[TB] FAIL rnd_err @%h: got cyc=%0d err=%b rdata=%h we=%0d expected cyc=1 err=1 rdata=0 we=0",
                   addr, obs_ack_cyc, obs_err, obs_rdata, obs_we_count);
        else n_pass++;
      end else if (we) begin
        n_checks++;
        if (obs_ack_cyc !== 2 || obs_err !== 1'b0 || obs_we_count !== 1 || obs_we_cyc !== 1 ||
            obs_we_val !== 3'(1 << dev) || obs_add !== 2'(rsel) || obs_dat !== wdata)
          $display("[TB] FAIL rnd_wr @%h: got cyc=%0d err=%b we=%b x%0d add=%0d dat=%h expected cyc=2 err=0 we=%b x1 add=%0d dat=%h",
                   addr, obs_ack_cyc, obs_err, obs_we_val, obs_we_count, obs_add, obs_dat, 3'(1 << dev), rsel, wdata);
        else n_pass++;
        if (rsel < 2) ref_regs[dev][rsel] = wdata;
      end else begin
        n_checks++;
        if (obs_ack_cyc !== 3 || obs_err !== 1'b0 || obs_we_count !== 0 || obs_rdata !== ref_regs[dev][rsel])
          $display("[TB] FAIL rnd_rd @%h: got cyc=%0d err=%b we=%0d rdata=%h expected cyc=3 err=0 we=0 rdata=%h",
                   addr, obs_ack_cyc, obs_err, obs_we_count, obs_rdata, ref_regs[dev][rsel]);
        else n_pass++;
      end
      n_checks++; if (cpu_ack_o !== 1'b0) $display("[TB] FAIL rnd_ack_pulse: got %b expected 0", cpu_ack_o); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_write();
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b1;
    cpu_addr_i  = 32'h7F20;
    cpu_wdata_i = $urandom;
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
    n_checks++; if (dev_we_o !== 3'b100) $display("[TB] FAIL mid_access_we: got %b expected 100", dev_we_o); else n_pass++;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    n_checks++; if (dev_we_o !== 3'b000) $display("[TB] FAIL mid_we_cut: got %b expected 000", dev_we_o); else n_pass++;
    n_checks++; if (cpu_ack_o !== 1'b0) $display("[TB] FAIL mid_no_ack: got %b expected 0", cpu_ack_o); else n_pass++;
    n_checks++; if (dev_dat_o !== 32'h0) $display("[TB] FAIL mid_dat_clr: got %h expected 0", dev_dat_o); else n_pass++;
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      n_checks++;
      if (dev_we_o !== 3'b000 || cpu_ack_o !== 1'b0)
        $display("[TB] FAIL mid_quiet: got we=%b ack=%b expected we=000 ack=0", dev_we_o, cpu_ack_o);
      else n_pass++;
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h0;
    cpu_wdata_i = 32'h0;
    dev_irq_i   = '0;
    for (int k = 0; k < N_DEV; k++) begin
      ref_regs[k][0] = 32'h0;
      ref_regs[k][1] = 32'h0;
      ref_regs[k][2] = 32'hC0DE_0000 + 32'(k);
    end
    test_reset();
    test_preset_write();
    test_read_after_write();
    test_decode_errors();
    test_irq();
    test_random();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dev_bridge.md
# dev_bridge

Bus bridge between the CPU data-memory port and the memory-mapped peripheral devices (timer/counters and future devices). It decodes CPU addresses in the device window and sequences one register access at a time to the selected device using the device register protocol: shared register index, one-hot write enable, 32-bit write data, and registered read data. It also registers device interrupt lines into the CPU hardware-interrupt vector.

## Interface
- `N_DEV`, 3: number of attached devices (1..6).
- `BASE`, 32'h0000_7F00: device window base. Device *k* occupies `BASE + 16*k` .. `BASE + 16*k + 11`.
- `clk_i` input 1: clock; all state updates on its rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `cpu_req_i` input 1: access request; sampled only in IDLE.
- `cpu_we_i` input 1: 1 = write, 0 = read.
- `cpu_addr_i` input 32: byte address.
- `cpu_wdata_i` input 32: write data.
- `cpu_ack_o` output 1: one-cycle completion pulse.
- `cpu_err_o` output 1: valid with `cpu_ack_o`; 1 = decode error.
- `cpu_rdata_o` output 32: read data; valid while `cpu_ack_o` is high.
- `hwint_o` output 6: registered interrupts; bit *k* comes from device *k*; bits ≥ `N_DEV` are 0.
- `dev_add_o` output `DEV_ADDR_WD` (2): register index = `cpu_addr_i[3:2]`; 0 = CTRL, 1 = PRESET, 2 = COUNT.
- `dev_we_o` output `N_DEV`: one-hot write enable.
- `dev_dat_o` output 32: write data to devices.
- `dev_dat_i` input `32*N_DEV`: device *k* read data in bits `[32k+31:32k]`; the device registers it from `dev_add_o` on each clock edge.
- `dev_irq_i` input `N_DEV`: device interrupt levels.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP, ERR.
- IDLE with `cpu_req_i` high:
  - Latch we, addr, and wdata.
  - Decode: device index = `(addr - BASE) >> 4`.
  - Decode is valid only if all of the following hold: addr ≥ BASE; device index < `N_DEV`; `addr[1:0]` = 0; `addr[3:2]` ≠ 3.
  - Valid decode goes to ACCESS. Invalid decode goes to ERR.
- ACCESS, one cycle:
  - `dev_add_o` = latched index, held from ACCESS through CAPTURE.
  - Write: `dev_we_o[k]` = 1 for this cycle only; `dev_dat_o` = latched wdata. Next state is RESP.
  - Read: `dev_we_o` = 0. Next state is CAPTURE.
- CAPTURE (read only), one cycle: the selected `dev_dat_i` slice now reflects the index. Register it into the `cpu_rdata_o` holding register at the end of the cycle. Next state is RESP.
- RESP: `cpu_ack_o` = 1 and `cpu_err_o` = 0. Next state is IDLE.
- ERR: `cpu_ack_o` = 1, `cpu_err_o` = 1, `cpu_rdata_o` = 0. No `dev_we_o` is asserted. Next state is IDLE.
- `cpu_req_i` is ignored outside IDLE. The CPU must deassert it in the ack cycle; if it is still high in the following IDLE cycle, that is a new request.
- Writes to COUNT (index 2) are forwarded normally; the device ignores them.
- `hwint_o[k]` <= `dev_irq_i[k]` every cycle (one-flop register). There is no latching or clearing; levels follow the devices.
- `dev_dat_o` holds its last value outside ACCESS. `dev_add_o` holds its last value in IDLE.
- Address arithmetic is unsigned 32-bit. When addr < BASE, the subtraction wraps and is treated as invalid.

## Timing
- Reset (sync, `rst_i` high at an edge):
  - State goes to IDLE.
  - `cpu_ack_o` = 0, `cpu_err_o` = 0, `cpu_rdata_o` = 0.
  - `dev_we_o` = 0, `dev_add_o` = 0, `dev_dat_o` = 0, `hwint_o` = 0.
- Reset in any state aborts the transaction with no ack. If reset occurs in ACCESS, the write pulse is suppressed from the next cycle on.
- Latency counted from the request-sampling edge (T0):
  - Write: `dev_we_o` high in cycle T0+1; ack in T0+2.
  - Read: index driven in T0+1; data captured at the end of T0+2; ack and `cpu_rdata_o` valid in T0+3.
  - Error: ack + err in T0+1.
- Throughput: one access per 3 cycles (write) or 4 cycles (read), including the IDLE cycle.
- `hwint_o` lags `dev_irq_i` by exactly 1 cycle.

## Test plan
- Reset then idle:
  - Hold `rst_i` for 2 cycles.
  - All outputs must be 0 and `dev_we_o` never pulses while `cpu_req_i` = 0.
- Timer 0 PRESET write:
  - Write 0x7F04 <- 32'd5.
  - `dev_we_o` = 3'b001, `dev_add_o` = 1, `dev_dat_o` = 5 for exactly one cycle (T0+1).
  - Ack at T0+2 with err = 0.
- Timer 1 CTRL read after write:
  - Write 0x7F10 <- 32'h9, then read 0x7F10.
  - Read ack at T0+3 with `cpu_rdata_o` = 32'h9; `dev_we_o` = 0 throughout the read.
- Decode errors:
  - Accesses to 0x7F0C (index 3), 0x7F02 (unaligned), 0x7F30 (device 3 ≥ `N_DEV`), and 0x7EFC (below base).
  - Each gets ack + err at T0+1, `cpu_rdata_o` = 0, and no `dev_we_o` pulse.
- Interrupt path: device 1 irq rises at cycle C, so `hwint_o` = 6'b000010 at C+1; it falls one cycle after irq falls.
- Reset mid-write: assert `rst_i` during ACCESS of a write to 0x7F20. No ack is issued and `dev_we_o` = 0 from the next cycle on.
